branch_predictor: RTL

- Fetch-side branch predictor. It is the prediction end of the taken/not-taken interface whose resolving end is the execute-stage branch condition unit.
- Provides a combinational taken/target prediction for the fetch PC from a direct-mapped BTB (branch target buffer) of 2-bit saturating counters.
- Is trained one cycle later by the resolved outcome from execute: branch class, actual taken, actual target.
- Lives beside the PC register in the fetch stage; the pipeline compares the prediction against the resolved outcome to redirect.

---
 rtl/branch_predictor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor. A direct-mapped BTB of 2-bit saturating
// counters gives a combinational taken/target prediction for pc_f. The BTB
// is trained by the branch outcome that execute resolves.
// Optional build macro BP_STATS_EN adds the stat_branches and
// stat_mispredicts counters.
module branch_predictor #(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];

  logic [IDX_W-1:0]  idx_f;
  logic [TAG_W-1:0]  tag_f;
  logic              hit_f;
  logic [IDX_W-1:0]  idx_u;
  logic [TAG_W-1:0]  tag_u;
  logic              hit_u;

  logic              wr_en;
  logic              wr_valid;
  logic [TAG_W-1:0]  wr_tag;
  logic [1:0]        wr_ctr;
  logic [31:0]       wr_target;

  logic              unused_bits;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[31:IDX_W+2];
  assign idx_u = upd_pc[IDX_W+1:2];
  assign tag_u = upd_pc[31:IDX_W+2];

  // Prediction: reads only the stored state, so there is no bypass of a same-cycle update.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken  = hit_f && ctr_q[idx_f][1];
    pred_target = pred_taken ? target_q[idx_f] : pc_f + 32'd4;
  end

  // Training decision: build the complete new entry for the resolved PC.
  always_comb begin
    hit_u     = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    wr_en     = 1'b0;
    wr_valid  = valid_q[idx_u];
    wr_tag    = tag_q[idx_u];
    wr_ctr    = ctr_q[idx_u];
    wr_target = target_q[idx_u];
    if (upd_valid) begin
      if (upd_is_jump) begin
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = tag_u;
        wr_ctr    = 2'b11;
        wr_target = upd_target;
      end else if (hit_u) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          wr_ctr    = (ctr_q[idx_u] == 2'b11) ? 2'b11 : ctr_q[idx_u] + 2'd1;
          wr_target = upd_target;
        end else begin
          wr_ctr    = (ctr_q[idx_u] == 2'b00) ? 2'b00 : ctr_q[idx_u] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever aliasing entry occupied this index.
        wr_en     = 1'b1;
        wr_valid  = 1'b1;
        wr_tag    = tag_u;
        wr_ctr    = 2'b10;
        wr_target = upd_target;
      end
    end
  end

  // BTB storage: asynchronous clear, and at most one entry written per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[idx_u]  <= wr_valid;
      tag_q[idx_u]    <= wr_tag;
      ctr_q[idx_u]    <= wr_ctr;
      target_q[idx_u] <= wr_target;
    end
  end

`ifdef BP_STATS_EN
  // Statistics: resolved control-flow count and the mispredicts among them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (upd_pred_taken != upd_taken) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

  assign unused_bits = ^{pc_f[1:0], upd_pc[1:0]};
`else
  assign unused_bits = ^{pc_f[1:0], upd_pc[1:0], upd_pred_taken};
`endif

endmodule
